// File: rtl/core_seq_pkg.sv
// Shared definitions for the NPC core sequencer: state encoding, halt causes
// and counter width.
package core_seq_pkg;

  localparam int YSYX_23060251_CNT_W = 64;

  typedef enum logic [2:0] {
    YSYX_23060251_ST_IDLE   = 3'd0,
    YSYX_23060251_ST_FETCH  = 3'd1,
    YSYX_23060251_ST_DECODE = 3'd2,
    YSYX_23060251_ST_EXEC   = 3'd3,
    YSYX_23060251_ST_MEM    = 3'd4,
    YSYX_23060251_ST_WB     = 3'd5,
    YSYX_23060251_ST_HALT   = 3'd6
  } ysyx_23060251_state_t;

  localparam logic [1:0] YSYX_23060251_CAUSE_NONE    = 2'b00;
  localparam logic [1:0] YSYX_23060251_CAUSE_EBREAK  = 2'b01;
  localparam logic [1:0] YSYX_23060251_CAUSE_ILLEGAL = 2'b10;
  localparam logic [1:0] YSYX_23060251_CAUSE_TIMEOUT = 2'b11;

  // States that wait on a bus acknowledge and therefore run the wait timer.
  function automatic logic ysyx_23060251_is_wait(input ysyx_23060251_state_t st);
    return (st == YSYX_23060251_ST_FETCH) || (st == YSYX_23060251_ST_MEM);
  endfunction

endpackage

// File: rtl/core_seq_wait_timer.sv
// Bus wait counter shared by FETCH and MEM; expired flags count == TIMEOUT.
module core_seq_wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT);

  logic [W-1:0] count_reg;

  assign expired = (count_reg == LIMIT);

  // Holds at the limit so a late ack still sees expired and never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en && !expired) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/core_seq.sv
// Multi-cycle instruction sequencer: one instruction in flight, halts on
// ebreak, illegal instruction or bus timeout, keeps cycle/instret counters.
module core_seq
  import core_seq_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_req_o,
  input  logic        ifu_ack_i,
  output logic        inst_we_o,
  input  logic        dec_is_load_i,
  input  logic        dec_is_store_i,
  input  logic        dec_is_ebreak_i,
  input  logic        dec_illegal_i,
  input  logic        dec_wb_en_i,
  output logic        lsu_req_o,
  output logic        lsu_we_o,
  input  logic        lsu_ack_i,
  output logic        rf_we_o,
  output logic        pc_we_o,
  output logic        halt_o,
  output logic [1:0]  halt_cause_o,
  output logic [63:0] cycle_o,
  output logic [63:0] instret_o
);

  ysyx_23060251_state_t state_reg;
  logic                 load_reg;
  logic                 store_reg;
  logic                 wb_en_reg;
  logic [1:0]           cause_reg;
  logic [YSYX_23060251_CNT_W-1:0] cycle_reg;
  logic [YSYX_23060251_CNT_W-1:0] instret_reg;

  logic timer_clr;
  logic timer_en;
  logic timer_expired;

  assign timer_clr = !ysyx_23060251_is_wait(state_reg);
  assign timer_en  = ((state_reg == YSYX_23060251_ST_FETCH) && !ifu_ack_i) ||
                     ((state_reg == YSYX_23060251_ST_MEM)   && !lsu_ack_i);

  core_seq_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= YSYX_23060251_ST_IDLE;
      load_reg    <= 1'b0;
      store_reg   <= 1'b0;
      wb_en_reg   <= 1'b0;
      cause_reg   <= YSYX_23060251_CAUSE_NONE;
      cycle_reg   <= '0;
      instret_reg <= '0;
    end else begin
      if (state_reg != YSYX_23060251_ST_HALT) begin
        cycle_reg <= cycle_reg + 64'd1;
      end
      case (state_reg)
        YSYX_23060251_ST_IDLE: begin
          state_reg <= YSYX_23060251_ST_FETCH;
        end
        YSYX_23060251_ST_FETCH: begin
          if (ifu_ack_i) begin
            state_reg <= YSYX_23060251_ST_DECODE;
          end else if (timer_expired) begin
            state_reg <= YSYX_23060251_ST_HALT;
            cause_reg <= YSYX_23060251_CAUSE_TIMEOUT;
          end
        end
        YSYX_23060251_ST_DECODE: begin
          load_reg  <= dec_is_load_i;
          store_reg <= dec_is_store_i;
          wb_en_reg <= dec_wb_en_i;
          // Illegal wins over ebreak and never retires.
          if (dec_illegal_i) begin
            state_reg <= YSYX_23060251_ST_HALT;
            cause_reg <= YSYX_23060251_CAUSE_ILLEGAL;
          end else if (dec_is_ebreak_i) begin
            state_reg   <= YSYX_23060251_ST_HALT;
            cause_reg   <= YSYX_23060251_CAUSE_EBREAK;
            instret_reg <= instret_reg + 64'd1;
          end else begin
            state_reg <= YSYX_23060251_ST_EXEC;
          end
        end
        YSYX_23060251_ST_EXEC: begin
          if (load_reg || store_reg) begin
            state_reg <= YSYX_23060251_ST_MEM;
          end else begin
            state_reg <= YSYX_23060251_ST_WB;
          end
        end
        YSYX_23060251_ST_MEM: begin
          if (lsu_ack_i) begin
            state_reg <= YSYX_23060251_ST_WB;
          end else if (timer_expired) begin
            state_reg <= YSYX_23060251_ST_HALT;
            cause_reg <= YSYX_23060251_CAUSE_TIMEOUT;
          end
        end
        YSYX_23060251_ST_WB: begin
          instret_reg <= instret_reg + 64'd1;
          state_reg   <= YSYX_23060251_ST_FETCH;
        end
        YSYX_23060251_ST_HALT: begin
          state_reg <= YSYX_23060251_ST_HALT;
        end
        default: begin
          state_reg <= YSYX_23060251_ST_IDLE;
        end
      endcase
    end
  end

  // Everything except inst_we_o is a pure decode of registered state.
  assign ifu_req_o    = (state_reg == YSYX_23060251_ST_FETCH);
  assign inst_we_o    = (state_reg == YSYX_23060251_ST_FETCH) && ifu_ack_i;
  assign lsu_req_o    = (state_reg == YSYX_23060251_ST_MEM);
  assign lsu_we_o     = (state_reg == YSYX_23060251_ST_MEM) && store_reg;
  assign pc_we_o      = (state_reg == YSYX_23060251_ST_WB);
  assign rf_we_o      = (state_reg == YSYX_23060251_ST_WB) && wb_en_reg && !store_reg;
  assign halt_o       = (state_reg == YSYX_23060251_ST_HALT);
  assign halt_cause_o = cause_reg;
  assign cycle_o      = cycle_reg;
  assign instret_o    = instret_reg;

endmodule
